// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP layer types, constants and IPv4 flags helper
package udp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PUSH
  } udp_transmit_state_type;

  localparam int UDP_HEADER_BYTES = 8;
  localparam int IPV4_MF_BIT      = 13;
  localparam int IPV4_DF_BIT      = 14;

  // Fragment offset is carried in 8-byte units; DF is never set by this layer.
  function automatic logic [15:0] ipv4_flags_word(input logic more_fragments,
                                                  input logic [15:0] offset_bytes);
    logic [15:0] w;
    w = {3'b000, offset_bytes[15:3]};
    w[IPV4_MF_BIT] = more_fragments;
    w[IPV4_DF_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/udp_transmit_handler_if.sv
// rtl/udp_transmit_handler_if.sv - queue, fragment header and byte stream signals
interface udp_transmit_handler_if #(
  parameter int TRANSMIT_QUE_SLOTS = 4
);

  logic [TRANSMIT_QUE_SLOTS-1:0]       enable;
  logic [TRANSMIT_QUE_SLOTS-1:0][15:0] datagram_length;
  logic [TRANSMIT_QUE_SLOTS-1:0][7:0]  data;
  logic [TRANSMIT_QUE_SLOTS-1:0]       data_enable;
  logic [TRANSMIT_QUE_SLOTS-1:0]       data_ready;

  logic        fragment_header_valid;
  logic        fragment_header_ready;
  logic [15:0] ipv4_identification;
  logic [15:0] ipv4_flags;
  logic [15:0] fragment_length;

  logic [7:0]  push_data;
  logic        push_data_valid;
  logic        push_data_ready;
  logic        push_data_last;
  logic        push_data_abort;

  modport master (
    input  enable, datagram_length, data, data_enable,
    input  fragment_header_ready, push_data_ready,
    output data_ready, fragment_header_valid, ipv4_identification, ipv4_flags,
    output fragment_length, push_data, push_data_valid, push_data_last, push_data_abort
  );

  modport slave (
    output enable, datagram_length, data, data_enable,
    output fragment_header_ready, push_data_ready,
    input  data_ready, fragment_header_valid, ipv4_identification, ipv4_flags,
    input  fragment_length, push_data, push_data_valid, push_data_last, push_data_abort
  );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - reloadable stall timer, built only with UDP_TRANSMIT_TIMEOUT_EN
`ifdef UDP_TRANSMIT_TIMEOUT_EN
module cycle_timer #(
  parameter logic [15:0] LIMIT = 16'h0004
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (reload) begin
      count <= LIMIT;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign expired = (count == 16'd0);

endmodule
`endif

// File: rtl/udp_transmit_handler.sv
// rtl/udp_transmit_handler.sv - round-robin UDP datagram fragmenter into IPv4 fragments
// Optional source-stall abort: UDP_TRANSMIT_TIMEOUT_EN
module udp_transmit_handler
  import udp_pkg::*;
#(
  parameter int          TRANSMIT_QUE_SLOTS   = 4,
  parameter int          MAX_FRAGMENT_PAYLOAD = 1480,
  parameter logic [15:0] TIMEOUT_LIMIT        = 16'h0004
) (
  input logic                    clock,
  input logic                    reset,
  udp_transmit_handler_if.master bus
);

  localparam int          SLOT_W  = $clog2(TRANSMIT_QUE_SLOTS);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAGMENT_PAYLOAD);

  udp_transmit_state_type state;
  logic [SLOT_W-1:0] slot;
  logic [15:0] remaining, bytes_sent, frag_count, id_counter;
  logic [15:0] ident, flags, frag_len, next_len, next_flags;
  logic [7:0]  pdata;
  logic        hdr_valid, pvalid, plast, take;
  logic [TRANSMIT_QUE_SLOTS-1:0] ready_vec;

  always_comb begin
    take = (state == S_PUSH) && bus.data_enable[slot] && (frag_count != 16'd0)
           && (!pvalid || bus.push_data_ready);
    ready_vec = '0;
    ready_vec[slot] = take;
    next_len   = (remaining > MAX_LEN) ? MAX_LEN : remaining;
    next_flags = ipv4_flags_word(remaining > MAX_LEN, bytes_sent);
  end

`ifdef UDP_TRANSMIT_TIMEOUT_EN
  logic pabort, timer_expired;

  cycle_timer #(.LIMIT(TIMEOUT_LIMIT)) u_cycle_timer (
    .clock  (clock),
    .reset  (reset),
    .reload (take || (state == S_HEADER)),
    .expired(timer_expired)
  );

  assign bus.push_data_abort = pabort;
`else
  wire unused_timeout_limit = ^TIMEOUT_LIMIT;
  assign bus.push_data_abort = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      slot       <= '0;
      remaining  <= 16'd0;
      bytes_sent <= 16'd0;
      frag_count <= 16'd0;
      id_counter <= 16'd0;
      ident      <= 16'd0;
      flags      <= 16'd0;
      frag_len   <= 16'd0;
      hdr_valid  <= 1'b0;
      pdata      <= 8'd0;
      pvalid     <= 1'b0;
      plast      <= 1'b0;
`ifdef UDP_TRANSMIT_TIMEOUT_EN
      pabort     <= 1'b0;
`endif
    end else begin
`ifdef UDP_TRANSMIT_TIMEOUT_EN
      pabort <= 1'b0;
`endif
      // Output byte register: refill on consume, otherwise drain on downstream accept.
      if (take) begin
        pdata      <= bus.data[slot];
        pvalid     <= 1'b1;
        plast      <= (frag_count == 16'd1);
        frag_count <= frag_count - 16'd1;
        remaining  <= remaining - 16'd1;
        bytes_sent <= bytes_sent + 16'd1;
      end else if (pvalid && bus.push_data_ready) begin
        pvalid <= 1'b0;
        plast  <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.enable[slot]) begin
            remaining  <= bus.datagram_length[slot];
            bytes_sent <= 16'd0;
            state      <= S_LOAD;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        S_LOAD: begin
          if (remaining < 16'(UDP_HEADER_BYTES)) begin
            state <= S_IDLE;
            slot  <= slot + SLOT_W'(1);
          end else begin
            ident      <= id_counter;
            id_counter <= id_counter + 16'd1;
            frag_len   <= next_len;
            flags      <= next_flags;
            hdr_valid  <= 1'b1;
            state      <= S_HEADER;
          end
        end
        S_HEADER: begin
          // Re-entry after a fragment spends one cycle computing the next header.
          if (!hdr_valid) begin
            frag_len  <= next_len;
            flags     <= next_flags;
            hdr_valid <= 1'b1;
          end else if (bus.fragment_header_ready) begin
            hdr_valid  <= 1'b0;
            frag_count <= frag_len;
            state      <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (pvalid && plast && bus.push_data_ready) begin
            if (remaining != 16'd0) begin
              state <= S_HEADER;
            end else begin
              state <= S_IDLE;
              slot  <= slot + SLOT_W'(1);
            end
          end
`ifdef UDP_TRANSMIT_TIMEOUT_EN
          else if (timer_expired && !take && (frag_count != 16'd0)) begin
            pvalid <= 1'b0;
            plast  <= 1'b0;
            pabort <= 1'b1;
            state  <= S_IDLE;
            slot   <= slot + SLOT_W'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_ready            = ready_vec;
  assign bus.fragment_header_valid = hdr_valid;
  assign bus.ipv4_identification   = ident;
  assign bus.ipv4_flags            = flags;
  assign bus.fragment_length       = frag_len;
  assign bus.push_data             = pdata;
  assign bus.push_data_valid       = pvalid;
  assign bus.push_data_last        = plast;

endmodule

// File: tb/tb_udp_transmit_handler.sv
// tb/tb_udp_transmit_handler.sv - directed self-checking bench for udp_transmit_handler
module tb_udp_transmit_handler;

  localparam int SLOTS = 4;

  typedef struct {
    logic [15:0] id;
    logic [15:0] flags;
    logic [15:0] len;
  } hdr_t;

  logic clock;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   src_idx [SLOTS];
  logic [7:0] got_q [$];
  logic       last_q [$];
  hdr_t       hdr_q [$];
  int   abort_cnt = 0;
  int   viol_cnt  = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  udp_transmit_handler_if #(.TRANSMIT_QUE_SLOTS(SLOTS)) bus ();

  udp_transmit_handler #(
    .TRANSMIT_QUE_SLOTS  (SLOTS),
    .MAX_FRAGMENT_PAYLOAD(1480),
    .TIMEOUT_LIMIT       (16'h0004)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(int s, int k);
    return 8'((k * 13 + s * 64 + 5) & 255);
  endfunction

  // Queue slot sources: each slot streams its own byte pattern.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) bus.data[s] = pat(s, src_idx[s]);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) src_idx[s] <= 0;
    end else begin
      for (int s = 0; s < SLOTS; s++)
        if (bus.data_ready[s]) src_idx[s] <= src_idx[s] + 1;
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (bus.push_data_valid && bus.push_data_ready) begin
        got_q.push_back(bus.push_data);
        last_q.push_back(bus.push_data_last);
      end
      if (bus.fragment_header_valid && bus.fragment_header_ready)
        hdr_q.push_back('{bus.ipv4_identification, bus.ipv4_flags, bus.fragment_length});
      if (bus.push_data_abort) abort_cnt++;
      if (prev_stall && (!bus.push_data_valid || bus.push_data !== prev_data)) viol_cnt++;
      if (bus.push_data_valid && !bus.push_data_ready && bus.data_ready != '0) viol_cnt++;
      prev_stall = bus.push_data_valid && !bus.push_data_ready;
      prev_data  = bus.push_data;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(int target, int budget, string tag);
    int n;
    n = 0;
    while (got_q.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(got_q.size() >= target), 1);
  endtask

  task automatic start_dgram(int s, logic [15:0] len, string tag);
    int hb;
    int n;
    hb = hdr_q.size();
    n  = 0;
    bus.datagram_length[s] = len;
    bus.enable[s] = 1'b1;
    while (hdr_q.size() <= hb && n < 200) begin
      @(negedge clock);
      n++;
    end
    bus.enable[s] = 1'b0;
    chk(tag, 32'(hdr_q.size() > hb), 1);
  endtask

  task automatic check_bytes(int base, int s, int k0, int n, string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (base + i >= got_q.size() || got_q[base + i] !== pat(s, k0 + i)) bad++;
    chk(tag, 32'(bad), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int gb;
    int hb;
    int ab;
    int n;
    int bad;
    logic [7:0] held;

    clock = 1'b0;
    reset = 1'b1;
    bus.enable = '0;
    bus.datagram_length = '0;
    bus.data_enable = '1;
    bus.fragment_header_ready = 1'b1;
    bus.push_data_ready = 1'b1;
    repeat (2) @(negedge clock);

    chk("rst_hdr_valid", 32'(bus.fragment_header_valid), 0);
    chk("rst_push_valid", 32'(bus.push_data_valid), 0);
    chk("rst_fields", {bus.ipv4_identification, bus.ipv4_flags}, 0);
    chk("rst_misc", {bus.fragment_length, bus.push_data, 4'(bus.data_ready),
                     bus.push_data_last, bus.push_data_abort}, 0);

    // Single-fragment datagram on slot 0, with header latency.
    gb = got_q.size();
    bus.datagram_length[0] = 16'd100;
    bus.enable[0] = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    chk("t1_hdr_not_yet", 32'(bus.fragment_header_valid), 0);
    @(negedge clock);
    chk("t1_hdr_valid", 32'(bus.fragment_header_valid), 1);
    chk("t1_hdr_fields", {bus.ipv4_identification, bus.ipv4_flags}, 32'h0000_0000);
    chk("t1_hdr_len", 32'(bus.fragment_length), 100);
    bus.enable[0] = 1'b0;
    wait_bytes(gb + 100, 400, "t1_bytes_timeout");
    check_bytes(gb, 0, 0, 100, "t1_byte_order");
    bad = 0;
    for (int i = 0; i < 100; i++) if (last_q[gb + i] !== (i == 99)) bad++;
    chk("t1_last_pos", 32'(bad), 0);

    // Three-fragment datagram on slot 1.
    gb = got_q.size();
    hb = hdr_q.size();
    start_dgram(1, 16'd3000, "t2_start");
    wait_bytes(gb + 3000, 4000, "t2_bytes_timeout");
    chk("t2_hdr_count", 32'(hdr_q.size() - hb), 3);
    chk("t2_h0", {hdr_q[hb].id, hdr_q[hb].flags}, 32'h0001_2000);
    chk("t2_h1", {hdr_q[hb+1].id, hdr_q[hb+1].flags}, 32'h0001_20B9);
    chk("t2_h2", {hdr_q[hb+2].id, hdr_q[hb+2].flags}, 32'h0001_0172);
    chk("t2_lens", {hdr_q[hb].len, hdr_q[hb+2].len}, {16'd1480, 16'd40});
    chk("t2_len_mid", 32'(hdr_q[hb+1].len), 1480);
    check_bytes(gb, 1, 0, 3000, "t2_byte_order");
    bad = 0;
    for (int i = 0; i < 3000; i++)
      if (last_q[gb + i] !== (i == 1479 || i == 2959 || i == 2999)) bad++;
    chk("t2_last_pos", 32'(bad), 0);

    // Slots 0 and 2 pending together after reset: slot 0 first.
    @(negedge clock);
    reset = 1'b1;
    gb = got_q.size();
    hb = hdr_q.size();
    bus.datagram_length[0] = 16'd20;
    bus.datagram_length[2] = 16'd30;
    bus.enable[0] = 1'b1;
    bus.enable[2] = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (hdr_q.size() < hb + 1 && n < 100) begin @(negedge clock); n++; end
    bus.enable[0] = 1'b0;
    while (hdr_q.size() < hb + 2 && n < 300) begin @(negedge clock); n++; end
    bus.enable[2] = 1'b0;
    chk("t3_hdr_count", 32'(hdr_q.size() - hb), 2);
    wait_bytes(gb + 50, 200, "t3_bytes_timeout");
    chk("t3_first", {hdr_q[hb].id, hdr_q[hb].len}, {16'd0, 16'd20});
    chk("t3_second", {hdr_q[hb+1].id, hdr_q[hb+1].len}, {16'd1, 16'd30});
    check_bytes(gb, 0, 0, 20, "t3_bytes_slot0");
    check_bytes(gb + 20, 2, 0, 30, "t3_bytes_slot2");

    // Downstream backpressure for 5 cycles mid-fragment.
    pulse_reset();
    gb = got_q.size();
    start_dgram(0, 16'd40, "t4_start");
    wait_bytes(gb + 10, 200, "t4_first10_timeout");
    bus.push_data_ready = 1'b0;
    held = bus.push_data;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.push_data !== held || bus.push_data_valid !== 1'b1 || bus.data_ready !== '0) bad++;
    end
    chk("t4_hold_stable", 32'(bad), 0);
    chk("t4_held_value", 32'(held), 32'(pat(0, 10)));
    bus.push_data_ready = 1'b1;
    wait_bytes(gb + 40, 200, "t4_bytes_timeout");
    repeat (10) @(negedge clock);
    chk("t4_no_dup", 32'(got_q.size() - gb), 40);
    check_bytes(gb, 0, 0, 40, "t4_byte_order");
    chk("t4_protocol", 32'(viol_cnt), 0);

    // Source stalls after 10 bytes.
    pulse_reset();
    gb = got_q.size();
    ab = abort_cnt;
    start_dgram(0, 16'd100, "t5_start");
    n = 0;
    while (src_idx[0] < 10 && n < 200) begin @(negedge clock); n++; end
    bus.data_enable[0] = 1'b0;
    repeat (20) @(negedge clock);
`ifdef UDP_TRANSMIT_TIMEOUT_EN
    chk("t5_abort_once", 32'(abort_cnt - ab), 1);
    chk("t5_valid_low", 32'(bus.push_data_valid), 0);
    bus.data_enable[0] = 1'b1;
    repeat (10) @(negedge clock);
    chk("t5_stopped", 32'(got_q.size() - gb), 10);
`else
    chk("t5_no_abort", 32'(abort_cnt - ab), 0);
    chk("t5_waiting", 32'(got_q.size() - gb), 10);
    bus.data_enable[0] = 1'b1;
    wait_bytes(gb + 100, 400, "t5_resume_timeout");
    check_bytes(gb, 0, 0, 100, "t5_byte_order");
`endif

    // Reset mid-push, then a malformed datagram, then a good one.
    gb = got_q.size();
    start_dgram(0, 16'd100, "t6_start");
    wait_bytes(gb + 20, 200, "t6_first20_timeout");
    chk("t6_id_before", 32'(bus.ipv4_identification), 1);
    bus.datagram_length[0] = 16'd5;
    bus.enable[0] = 1'b1;
    reset = 1'b1;
    #1;
    chk("t6_rst_now", {bus.ipv4_identification, 7'd0, bus.push_data_valid, bus.push_data}, 0);
    chk("t6_rst_misc", {4'(bus.data_ready), bus.fragment_header_valid, bus.push_data_last,
                        bus.ipv4_flags}, 0);
    @(negedge clock);
    reset = 1'b0;
    gb = got_q.size();
    hb = hdr_q.size();
    repeat (20) @(negedge clock);
    bus.enable[0] = 1'b0;
    chk("t6_malformed_silent", {16'(hdr_q.size() - hb), 16'(got_q.size() - gb)}, 0);
    start_dgram(1, 16'd12, "t6_next_start");
    chk("t6_next_hdr", {hdr_q[hb].id, hdr_q[hb].len}, {16'd0, 16'd12});
    wait_bytes(gb + 12, 200, "t6_bytes_timeout");
    check_bytes(gb, 1, 0, 12, "t6_byte_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
